// File: rtl/data_distributor.sv
// Data distributor: four 16-bit output slots, written either one at a time
// (direct write) or as a four-sample burst capture that may contain gaps.
// Every output comes straight from a register.
module data_distributor #(
   parameter logic [15:0] RESET_VALUE = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] data_in,
   input  logic        wr_en,
   input  logic [1:0]  wr_sel,
   input  logic        burst_start,
   input  logic        in_valid,
   input  logic        burst_abort,
   output logic [15:0] data0,
   output logic [15:0] data1,
   output logic [15:0] data2,
   output logic [15:0] data3,
   output logic [3:0]  slot_valid,
   output logic        busy,
   output logic        done
);

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StCapture = 2'd1;
   localparam logic [1:0] StDone    = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [1:0]  ptr_q, ptr_d;
   logic [15:0] data_q [4];
   logic [15:0] data_d [4];
   logic [3:0]  slot_valid_q, slot_valid_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   // Next-state logic for the FSM, slot pointer and slot contents
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      data_d       = data_q;
      slot_valid_d = slot_valid_q;

      case (state_q)
         StIdle: begin
            // burst_start takes priority; a simultaneous direct write is dropped
            if (burst_start) begin
               state_d      = StCapture;
               ptr_d        = 2'd0;
               slot_valid_d = 4'b0000;
            end else if (wr_en) begin
               data_d[wr_sel]       = data_in;
               slot_valid_d[wr_sel] = 1'b1;
            end
         end
         StCapture: begin
            // Abort wins over a sample arriving in the same cycle
            if (burst_abort) begin
               state_d = StIdle;
            end else if (in_valid) begin
               data_d[ptr_q]       = data_in;
               slot_valid_d[ptr_q] = 1'b1;
               ptr_d               = ptr_q + 2'd1;
               if (ptr_q == 2'd3) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            ptr_d   = 2'd0;
         end
      endcase
   end

   // Status flags are registered copies of the next state so that they
   // line up with the state register without a combinational output path
   always_comb begin
      busy_d = (state_d == StCapture);
      done_d = (state_d == StDone);
   end

   // State registers with synchronous active-high reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         ptr_q        <= 2'd0;
         slot_valid_q <= 4'b0000;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            data_q[i] <= RESET_VALUE;
         end
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         slot_valid_q <= slot_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         for (int i = 0; i < 4; i++) begin
            data_q[i] <= data_d[i];
         end
      end
   end

   assign data0      = data_q[0];
   assign data1      = data_q[1];
   assign data2      = data_q[2];
   assign data3      = data_q[3];
   assign slot_valid = slot_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_data_distributor.sv
// Directed self-checking bench for data_distributor.
module tb_data_distributor;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] data_in;
   logic        wr_en;
   logic [1:0]  wr_sel;
   logic        burst_start;
   logic        in_valid;
   logic        burst_abort;
   logic [15:0] data0, data1, data2, data3;
   logic [3:0]  slot_valid;
   logic        busy;
   logic        done;

   int checks   = 0;
   int failures = 0;

   data_distributor #(.RESET_VALUE(16'h0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .data_in     (data_in),
      .wr_en       (wr_en),
      .wr_sel      (wr_sel),
      .burst_start (burst_start),
      .in_valid    (in_valid),
      .burst_abort (burst_abort),
      .data0       (data0),
      .data1       (data1),
      .data2       (data2),
      .data3       (data3),
      .slot_valid  (slot_valid),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [15:0] samples [4];
   bit          pattern [6];
   int          busy_cycles;
   int          done_cycles;
   int          k;

   initial begin
      rst = 1'b1; data_in = '0; wr_en = 0; wr_sel = '0;
      burst_start = 0; in_valid = 0; burst_abort = 0;

      // Reset
      tick(); tick();
      rst = 1'b0;
      check_eq("rst_data0", data0, 16'h0000);
      check_eq("rst_data1", data1, 16'h0000);
      check_eq("rst_data2", data2, 16'h0000);
      check_eq("rst_data3", data3, 16'h0000);
      check_eq("rst_valid", {12'd0, slot_valid}, 16'h0000);
      check_eq("rst_busy", {15'd0, busy}, 16'h0000);
      check_eq("rst_done", {15'd0, done}, 16'h0000);

      // Direct writes
      wr_en = 1; wr_sel = 2'd2; data_in = 16'hA5A5;
      tick();
      check_eq("wr2_data2", data2, 16'hA5A5);
      check_eq("wr2_valid", {12'd0, slot_valid}, 16'h0004);
      wr_sel = 2'd0; data_in = 16'h1234;
      tick();
      wr_en = 0;
      check_eq("wr0_data0", data0, 16'h1234);
      check_eq("wr0_data1", data1, 16'h0000);
      check_eq("wr0_data2", data2, 16'hA5A5);
      check_eq("wr0_data3", data3, 16'h0000);
      check_eq("wr0_valid", {12'd0, slot_valid}, 16'h0005);
      // Abort in IDLE does nothing
      burst_abort = 1;
      tick();
      burst_abort = 0;
      check_eq("idle_abort_busy", {15'd0, busy}, 16'h0000);
      check_eq("idle_abort_valid", {12'd0, slot_valid}, 16'h0005);

      // Gapped burst; wr_en/burst_start toggled during gaps must be ignored
      samples[0] = 16'h0011; samples[1] = 16'h0022;
      samples[2] = 16'h0033; samples[3] = 16'h0044;
      pattern[0] = 1; pattern[1] = 0; pattern[2] = 1;
      pattern[3] = 1; pattern[4] = 0; pattern[5] = 1;
      busy_cycles = 0; done_cycles = 0; k = 0;
      burst_start = 1;
      tick();
      burst_start = 0;
      check_eq("burst_start_busy", {15'd0, busy}, 16'h0001);
      check_eq("burst_start_valid", {12'd0, slot_valid}, 16'h0000);
      check_eq("burst_start_keep0", data0, 16'h1234);
      busy_cycles += busy;
      done_cycles += done;
      for (int i = 0; i < 6; i++) begin
         in_valid = pattern[i];
         if (pattern[i]) begin
            data_in = samples[k];
            k++;
            wr_en = 0; burst_start = 0;
         end else begin
            data_in = 16'hDEAD;
            wr_en = 1; wr_sel = 2'd1; burst_start = 1;
         end
         tick();
         busy_cycles += busy;
         done_cycles += done;
      end
      in_valid = 0; burst_start = 0;
      check_eq("burst_done_pulse", {15'd0, done}, 16'h0001);
      check_eq("burst_done_busy", {15'd0, busy}, 16'h0000);
      // Inputs during DONE are ignored
      wr_en = 1; wr_sel = 2'd0; data_in = 16'hFFFF; burst_start = 1;
      tick();
      wr_en = 0; burst_start = 0;
      busy_cycles += busy;
      done_cycles += done;
      check_eq("burst_data0", data0, 16'h0011);
      check_eq("burst_data1", data1, 16'h0022);
      check_eq("burst_data2", data2, 16'h0033);
      check_eq("burst_data3", data3, 16'h0044);
      check_eq("burst_valid", {12'd0, slot_valid}, 16'h000F);
      check_eq("burst_busy_cycles", busy_cycles[15:0], 16'd6);
      check_eq("burst_done_cycles", done_cycles[15:0], 16'd1);

      // Priority: burst_start beats a simultaneous direct write
      burst_start = 1; wr_en = 1; wr_sel = 2'd1; data_in = 16'hBEEF;
      tick();
      burst_start = 0; wr_en = 0;
      check_eq("prio_busy", {15'd0, busy}, 16'h0001);
      check_eq("prio_valid", {12'd0, slot_valid}, 16'h0000);
      check_eq("prio_data1", data1, 16'h0022);

      // Abort after two samples, with a third sample offered alongside abort
      in_valid = 1; data_in = 16'h0101;
      tick();
      data_in = 16'h0202;
      tick();
      check_eq("abort_pre_valid", {12'd0, slot_valid}, 16'h0003);
      burst_abort = 1; data_in = 16'h0303;
      tick();
      burst_abort = 0; in_valid = 0;
      check_eq("abort_busy", {15'd0, busy}, 16'h0000);
      check_eq("abort_done", {15'd0, done}, 16'h0000);
      check_eq("abort_valid", {12'd0, slot_valid}, 16'h0003);
      check_eq("abort_data2", data2, 16'h0033);
      check_eq("abort_data1", data1, 16'h0202);
      wr_en = 1; wr_sel = 2'd3; data_in = 16'h7777;
      tick();
      wr_en = 0;
      check_eq("abort_wr_data3", data3, 16'h7777);
      check_eq("abort_wr_valid", {12'd0, slot_valid}, 16'h000B);
      check_eq("abort_wr_done", {15'd0, done}, 16'h0000);

      // Reset in the middle of a burst
      burst_start = 1;
      tick();
      burst_start = 0;
      in_valid = 1; data_in = 16'h0909;
      tick();
      check_eq("midrst_pre_valid", {12'd0, slot_valid}, 16'h0001);
      check_eq("midrst_pre_data0", data0, 16'h0909);
      rst = 1; data_in = 16'h0808;
      tick();
      rst = 0; in_valid = 0;
      check_eq("midrst_data0", data0, 16'h0000);
      check_eq("midrst_data1", data1, 16'h0000);
      check_eq("midrst_data2", data2, 16'h0000);
      check_eq("midrst_data3", data3, 16'h0000);
      check_eq("midrst_valid", {12'd0, slot_valid}, 16'h0000);
      check_eq("midrst_busy", {15'd0, busy}, 16'h0000);
      check_eq("midrst_done", {15'd0, done}, 16'h0000);
      tick();
      check_eq("midrst_after_done", {15'd0, done}, 16'h0000);
      check_eq("midrst_after_busy", {15'd0, busy}, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/data_distributor.md
DATA_DISTRIBUTOR -- requirements
Module: data_distributor

Interface
REQ-001 The block SHALL have parameter RESET_VALUE, default 16'h0000, giving the reset content of every output word.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have port data_in, input, 16 bits, the word to be stored.
REQ-005 The block SHALL have port wr_en, input, 1 bit, a direct-write strobe.
REQ-006 The block SHALL have port wr_sel, input, 2 bits, the target slot for a direct write.
REQ-007 The block SHALL have port burst_start, input, 1 bit, a request to capture four consecutive samples into slots 0..3.
REQ-008 The block SHALL have port in_valid, input, 1 bit, qualifying data_in during a burst.
REQ-009 The block SHALL have port burst_abort, input, 1 bit, which terminates a burst early.
REQ-010 The block SHALL have ports data0, data1, data2 and data3, each output, 16 bits, registered slot contents.
REQ-011 The block SHALL have port slot_valid, output, 4 bits; bit n is set when slot n holds a written value.
REQ-012 The block SHALL have port busy, output, 1 bit, which is high while in CAPTURE.
REQ-013 The block SHALL have port done, output, 1 bit, a one-cycle pulse when a burst completes.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, CAPTURE and DONE; it SHALL use a 2-bit pointer ptr.
REQ-015 In IDLE with wr_en=1 and burst_start=0, data_in SHALL be written to slot wr_sel and slot_valid[wr_sel] set; the new value is visible on the next cycle (1-cycle latency).
REQ-016 In IDLE, a direct write SHALL leave the other three slots and their valid bits unchanged.
REQ-017 In IDLE with burst_start=1, the block SHALL go to CAPTURE, set ptr=0 and clear slot_valid to 4'b0000; slot data SHALL be retained.
REQ-018 If burst_start and wr_en are both high in IDLE, burst_start SHALL win and the direct write SHALL be dropped.
REQ-019 In CAPTURE, each cycle with in_valid=1 SHALL write data_in to slot ptr, set slot_valid[ptr] and increment ptr.
REQ-020 In CAPTURE, a cycle with in_valid=0 SHALL hold all state; gaps of any length are allowed.
REQ-021 In CAPTURE, when the write at ptr=3 occurs, the next state SHALL be DONE and ptr SHALL wrap to 0.
REQ-022 In CAPTURE, wr_en and burst_start SHALL be ignored.
REQ-023 In CAPTURE, burst_abort=1 SHALL return the FSM to IDLE with no write that cycle, even if in_valid=1; already-captured slots and their valid bits SHALL be kept, and no done pulse is issued.
REQ-024 DONE SHALL last exactly one cycle with done=1 and busy=0, then go to IDLE.
REQ-025 Inputs SHALL be ignored while in DONE.
REQ-026 busy SHALL be high exactly in the cycles the FSM is in CAPTURE.
REQ-027 All outputs SHALL be driven directly from registers, with no combinational path from input to output.
REQ-028 burst_abort in IDLE or DONE SHALL have no effect.

Reset
REQ-029 With rst=1 at a clock edge, data0..data3 SHALL take RESET_VALUE, slot_valid 4'b0000, busy 0, done 0, state IDLE and ptr 0.
REQ-030 rst SHALL override every other input, including mid-burst, and SHALL abort a burst without a done pulse.

Verification
REQ-031 Reset check: assert rst for 2 cycles -> all data outputs 16'h0000, slot_valid 0, busy 0, done 0.
REQ-032 Direct writes: write 16'hA5A5 to slot 2, then 16'h1234 to slot 0 -> data2=A5A5, data0=1234, slot_valid=4'b0101, other slots unchanged.
REQ-033 Gapped burst: burst_start, then in_valid pattern 1,0,1,1,0,1 with data 11,22,33,44 -> data0..3=0011,0022,0033,0044; busy high for 6 cycles; done high 1 cycle; slot_valid=4'b1111.
REQ-034 Priority: burst_start and wr_en(sel=1) in the same cycle -> CAPTURE entered, slot 1 not written, slot_valid=0.
REQ-035 Abort: a burst with 2 samples then burst_abort plus in_valid -> slot_valid=4'b0011, third sample not stored, no done, IDLE; a direct write is accepted the next cycle.
REQ-036 Reset mid-burst: rst after 1 sample -> all slots RESET_VALUE, slot_valid 0, busy 0, no done.
